mrv32_mem_arbiter: RTL
======================

Name: mrv32_mem_arbiter

Overview:
- Shares one single-ported memory between the core's instruction-fetch port (A) and LSU data port (B).
- Sits between mrv32_core and the unified RAM/bus.
- One transaction outstanding at a time; two-way round-robin arbitration on contention.
- Response timeout returns a dummy response so a dead slave cannot hang the pipeline.

Parameters:
- ADDR_WIDTH, mrv32_pkg::ADDR_WIDTH, byte address width of all ports.
- TIMEOUT_CYCLES, 256, max cycles in ARB_WAIT before forced completion; 0 disables the timeout.
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- a_valid  in  1  fetch request; held with its payload until a_rvalid
- a_addr  in  ADDR_WIDTH  fetch address
- a_wdata  in  32  fetch write data (normally unused)
- a_wstrb  in  4  fetch byte strobes; 0 = read
- a_rdata  out  32  read data to fetch
- a_rvalid  out  1  one-cycle completion pulse to fetch
- b_valid  in  1  LSU request; held until b_rvalid
- b_addr  in  ADDR_WIDTH  LSU address
- b_wdata  in  32  LSU store data
- b_wstrb  in  4  LSU byte strobes; 0 = read
- b_rdata  out  32  read data to LSU
- b_rvalid  out  1  one-cycle completion pulse to LSU
- m_valid  out  1  request to memory
- m_addr  out  ADDR_WIDTH  memory address
- m_wdata  out  32  memory write data
- m_wstrb  out  4  memory strobes
- m_ready  in  1  memory accepts the request this cycle
- m_rdata  in  32  memory read data, valid with m_rvalid
- m_rvalid  in  1  memory response; pulsed for both reads and writes
- timeout_err  out  1  one-cycle pulse when a transaction is force-completed
- busy  out  1  high whenever the state is not ARB_IDLE

Behaviour:
- Reset (asynchronous, active-high): state=ARB_IDLE, gnt=A, last_gnt=A, counter=0.
- Reset values of outputs: m_valid, m_addr, m_wdata, m_wstrb, a_rvalid, b_rvalid and timeout_err are 0. busy is 0.
- Reset asserted mid-transaction drops the transaction; no rvalid is ever issued for it.
- Registered outputs: m_valid, m_addr, m_wdata, m_wstrb.
- Combinational outputs: a_rvalid, b_rvalid, a_rdata, b_rdata, timeout_err.
- ARB_IDLE:
  - If a_valid or b_valid is high: pick the winner, latch its addr/wdata/wstrb into the m_* registers, set m_valid=1, set gnt=winner, go to ARB_REQ.
  - Only one valid high: that requester wins.
  - Both high: the requester != last_gnt wins. With last_gnt reset to A, the first contention goes to B.
- ARB_REQ:
  - m_valid is held with stable payload until m_ready=1.
  - On m_ready: clear m_valid, counter=0, go to ARB_WAIT.
  - If m_rvalid=1 in the same cycle as m_ready (zero-latency slave): complete immediately (see completion) and go to ARB_IDLE.
- ARB_WAIT:
  - counter increments every cycle.
  - On m_rvalid: complete and go to ARB_IDLE.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no m_rvalid: force-complete. The granted rvalid pulses with rdata=0, timeout_err pulses, go to ARB_IDLE.
  - m_rvalid in the timeout cycle takes precedence: normal completion, no error.
- Completion:
  - gnt_rvalid=1 for exactly one cycle; the other requester's rvalid stays 0.
  - x_rdata=m_rdata for the granted port; the non-granted port's rdata=0.
  - last_gnt<=gnt.
- Minimum latency: valid seen at cycle 0 → m_valid at cycle 1 → rvalid at cycle 1 at the earliest (zero-latency slave).
- Requester protocol:
  - valid may stay high after rvalid. A valid seen in ARB_IDLE on the cycle after rvalid is treated as a new request.
  - In ARB_IDLE, valid and payload are sampled on the arbitration cycle only.
- A requester's valid dropping while it is not granted has no effect.
- m_rvalid is ignored in ARB_IDLE and ARB_REQ unless it coincides with m_ready in ARB_REQ.
- Constraint: a stray late response after a timeout can be mistaken for the next transaction's response. The slave must not respond after the timeout window.
- m_rdata is passed through unregistered; there is no buffering.
- busy = (state != ARB_IDLE).

Decomposition:
- mrv32_pkg additions:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_REQ, ARB_WAIT}.
  - typedef enum logic arb_sel_t {ARB_SEL_A, ARB_SEL_B}.
  - localparam ARB_TIMEOUT_DEFAULT = 256.
- Sub-module mrv32_rr_pick2: inputs req_a, req_b, last_gnt; outputs any_req, winner. Purely combinational; reusable for later arbiters.

Test Plan:
- Single read: a_valid, addr=0x100; slave m_ready at cycle 1, m_rvalid+rdata=0xDEADBEEF at cycle 3 → a_rvalid pulses once at cycle 3 with a_rdata=0xDEADBEEF; b_rvalid stays 0; busy high for cycles 1-3.
- Contention after reset: a_valid and b_valid both high at cycle 0 → B granted first (m_addr=b_addr), then A. A third back-to-back pair → B again (alternation B,A,B,A).
- Write pass-through: b_wstrb=0x3, b_wdata=0x1234ABCD, m_ready held low 4 cycles → m_valid and payload stable for all 4 cycles; b_rvalid is issued only after m_rvalid.
- Zero-latency slave: m_ready and m_rvalid both high in the first ARB_REQ cycle → rvalid in that same cycle, state ARB_IDLE next cycle, a new request accepted immediately.
- Timeout: TIMEOUT_CYCLES=8, slave never responds → a_rvalid and timeout_err pulse exactly 8 cycles after acceptance, a_rdata=0, then the next request proceeds normally.
- Reset mid-transaction: rst asserted in ARB_WAIT → all outputs 0 asynchronously, no rvalid pulse, and after release the first contention grants B.

Source files
------------

// File: rtl/mrv32_pkg.sv
// Shared types and constants for the mrv32 core slice.
// The memory arbiter's state and grant encodings live here.
package mrv32_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic {
    ARB_SEL_A,
    ARB_SEL_B
  } arb_sel_t;

endpackage

// File: rtl/mrv32_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on contention the
// requester that was not granted last time wins.
module mrv32_rr_pick2
  import mrv32_pkg::*;
(
  input  logic     req_a,
  input  logic     req_b,
  input  arb_sel_t last_gnt,
  output logic     any_req,
  output arb_sel_t winner
);

  always_comb begin
    any_req = req_a | req_b;
    winner  = ARB_SEL_A;
    if (req_a && req_b) begin
      winner = (last_gnt == ARB_SEL_A) ? ARB_SEL_B : ARB_SEL_A;
    end else if (req_b) begin
      winner = ARB_SEL_B;
    end
  end

endmodule

// File: rtl/mrv32_mem_arbiter.sv
// Shares one single-ported memory between fetch (A) and LSU (B) ports,
// one transaction outstanding, with a response timeout.
module mrv32_mem_arbiter
  import mrv32_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = mrv32_pkg::ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]           a_wdata,
  input  logic [3:0]            a_wstrb,
  output logic [31:0]           a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [31:0]           b_wdata,
  input  logic [3:0]            b_wstrb,
  output logic [31:0]           b_rdata,
  output logic                  b_rvalid,
  output logic                  m_valid,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  input  logic                  m_ready,
  input  logic [31:0]           m_rdata,
  input  logic                  m_rvalid,
  output logic                  timeout_err,
  output logic                  busy
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int unsigned CW = (CNT_WIDTH == 0) ? 1 : CNT_WIDTH;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  arb_state_t    state;
  arb_sel_t      gnt;
  arb_sel_t      last_gnt;
  logic [CW-1:0] cnt;

  logic     any_req;
  arb_sel_t winner;
  logic     resp_ok;
  logic     to_fire;
  logic     done;

  mrv32_rr_pick2 u_pick (
    .req_a    (a_valid),
    .req_b    (b_valid),
    .last_gnt (last_gnt),
    .any_req  (any_req),
    .winner   (winner)
  );

  always_comb begin
    resp_ok = ((state == ARB_REQ) && m_ready && m_rvalid) ||
              ((state == ARB_WAIT) && m_rvalid);
    to_fire = (TIMEOUT_CYCLES != 0) && (state == ARB_WAIT) &&
              (cnt == TO_LAST) && !m_rvalid;
    done        = resp_ok | to_fire;
    a_rvalid    = done && (gnt == ARB_SEL_A);
    b_rvalid    = done && (gnt == ARB_SEL_B);
    a_rdata     = (resp_ok && (gnt == ARB_SEL_A)) ? m_rdata : '0;
    b_rdata     = (resp_ok && (gnt == ARB_SEL_B)) ? m_rdata : '0;
    timeout_err = to_fire;
    busy        = (state != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      gnt      <= ARB_SEL_A;
      last_gnt <= ARB_SEL_A;
      cnt      <= '0;
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            gnt     <= winner;
            m_valid <= 1'b1;
            m_addr  <= (winner == ARB_SEL_B) ? b_addr  : a_addr;
            m_wdata <= (winner == ARB_SEL_B) ? b_wdata : a_wdata;
            m_wstrb <= (winner == ARB_SEL_B) ? b_wstrb : a_wstrb;
            state   <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            cnt     <= '0;
            if (m_rvalid) begin
              last_gnt <= gnt;
              state    <= ARB_IDLE;
            end else begin
              state <= ARB_WAIT;
            end
          end
        end
        ARB_WAIT: begin
          cnt <= cnt + CW'(1);
          if (done) begin
            last_gnt <= gnt;
            state    <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
